// File: rtl/cond_flag_stage_pkg.sv
// Shared definitions for the execute-stage condition/flag logic:
// condition-code encodings and status-flag bit positions.
package cond_flag_stage_pkg;

  localparam int ALU_FLAGS_WIDTH = 5;

  localparam int FLAG_Q = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_code_e;

endpackage

// File: rtl/cond_flag_stage_cond_check.sv
// Combinational condition-code evaluator: maps a 4-bit condition and the
// {N,Z,C,V} flags to a pass/fail bit.
module cond_check
  import cond_flag_stage_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;

  always_comb begin
    n = nzcv_i[FLAG_N];
    z = nzcv_i[FLAG_Z];
    c = nzcv_i[FLAG_C];
    v = nzcv_i[FLAG_V];
    pass_o = 1'b0;
    case (cond_code_e'(cond_i))
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~(c & ~z);
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = ~(~z & (n == v));
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_stage.sv
// Execute-stage condition/flag stage: evaluates the condition against the
// architectural flags, gates controls into the E/M register, updates flags.
module cond_flag_stage #(
  parameter int ALU_FLAGS_WIDTH = cond_flag_stage_pkg::ALU_FLAGS_WIDTH,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_e,
  input  logic [3:0]                 cond_e,
  input  logic [1:0]                 flags_write_e,
  input  logic [ALU_FLAGS_WIDTH-1:0] alu_flags_e,
  input  logic                       reg_write_e,
  input  logic                       mem_write_e,
  input  logic                       pc_src_e,
  input  logic                       stall_e,
  input  logic                       flush_e,
  input  logic                       clr_q,
  output logic                       cond_ex_e,
  output logic                       branch_taken_e,
  output logic [ALU_FLAGS_WIDTH-1:0] flags_q,
  output logic                       valid_m,
  output logic                       reg_write_m,
  output logic                       mem_write_m,
  output logic                       pc_src_m,
  output logic [CNT_WIDTH-1:0]       cond_fail_cnt
);

  import cond_flag_stage_pkg::*;

  logic [ALU_FLAGS_WIDTH-1:0] flags_d;
  logic                       valid_m_d, valid_m_q;
  logic                       reg_write_m_d, reg_write_m_q;
  logic                       mem_write_m_d, mem_write_m_q;
  logic                       pc_src_m_d, pc_src_m_q;
  logic [CNT_WIDTH-1:0]       cnt_d, cnt_q;
  logic                       live, go, q_set;

  cond_check u_cond_check (
    .cond_i (cond_e),
    .nzcv_i (flags_q[3:0]),
    .pass_o (cond_ex_e)
  );

  always_comb begin
    live           = valid_e & ~flush_e;
    go             = live & cond_ex_e;
    branch_taken_e = go & pc_src_e;

    flags_d = flags_q;
    if (go && flags_write_e[1]) begin
      flags_d[FLAG_N] = alu_flags_e[FLAG_N];
      flags_d[FLAG_Z] = alu_flags_e[FLAG_Z];
    end
    if (go && flags_write_e[0]) begin
      flags_d[FLAG_C] = alu_flags_e[FLAG_C];
      flags_d[FLAG_V] = alu_flags_e[FLAG_V];
    end
    // Q is sticky: a saturating op in the same cycle as a clear wins.
    q_set = go & (|flags_write_e) & alu_flags_e[FLAG_Q];
    if (q_set) begin
      flags_d[FLAG_Q] = 1'b1;
    end else if (clr_q) begin
      flags_d[FLAG_Q] = 1'b0;
    end

    valid_m_d     = live;
    reg_write_m_d = go & reg_write_e;
    mem_write_m_d = go & mem_write_e;
    pc_src_m_d    = go & pc_src_e;

    cnt_d = cnt_q;
    if (live && !cond_ex_e && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q       <= '0;
      valid_m_q     <= 1'b0;
      reg_write_m_q <= 1'b0;
      mem_write_m_q <= 1'b0;
      pc_src_m_q    <= 1'b0;
      cnt_q         <= '0;
    end else if (!stall_e) begin
      flags_q       <= flags_d;
      valid_m_q     <= valid_m_d;
      reg_write_m_q <= reg_write_m_d;
      mem_write_m_q <= mem_write_m_d;
      pc_src_m_q    <= pc_src_m_d;
      cnt_q         <= cnt_d;
    end
  end

  assign valid_m       = valid_m_q;
  assign reg_write_m   = reg_write_m_q;
  assign mem_write_m   = mem_write_m_q;
  assign pc_src_m      = pc_src_m_q;
  assign cond_fail_cnt = cnt_q;

endmodule

// File: tb/tb_cond_flag_stage.sv
// Self-checking bench for cond_flag_stage: directed scenarios plus random
// traffic compared against a behavioural model of the flag/condition rules.
module tb_cond_flag_stage;

  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_e;
  logic [3:0]    cond_e;
  logic [1:0]    flags_write_e;
  logic [4:0]    alu_flags_e;
  logic          reg_write_e, mem_write_e, pc_src_e;
  logic          stall_e, flush_e, clr_q;
  logic          cond_ex_e, branch_taken_e;
  logic [4:0]    flags_q;
  logic          valid_m, reg_write_m, mem_write_m, pc_src_m;
  logic [CW-1:0] cond_fail_cnt;

  int checks = 0;
  int errors = 0;

  logic [4:0] m_flags;
  logic       m_valid, m_rw, m_mw, m_pc;
  int         m_cnt;

  always #5 clk = ~clk;

  cond_flag_stage #(.ALU_FLAGS_WIDTH(5), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_e        (valid_e),
    .cond_e         (cond_e),
    .flags_write_e  (flags_write_e),
    .alu_flags_e    (alu_flags_e),
    .reg_write_e    (reg_write_e),
    .mem_write_e    (mem_write_e),
    .pc_src_e       (pc_src_e),
    .stall_e        (stall_e),
    .flush_e        (flush_e),
    .clr_q          (clr_q),
    .cond_ex_e      (cond_ex_e),
    .branch_taken_e (branch_taken_e),
    .flags_q        (flags_q),
    .valid_m        (valid_m),
    .reg_write_m    (reg_write_m),
    .mem_write_m    (mem_write_m),
    .pc_src_m       (pc_src_m),
    .cond_fail_cnt  (cond_fail_cnt)
  );

  // Reference condition table; flags vector is {Q,N,Z,C,V}.
  function automatic logic ref_cond(input logic [3:0] c, input logic [4:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = 5'b0; m_valid = 0; m_rw = 0; m_mw = 0; m_pc = 0; m_cnt = 0;
  endtask

  task automatic idle();
    valid_e = 0; cond_e = 4'b1110; flags_write_e = 2'b00; alu_flags_e = 5'b0;
    reg_write_e = 0; mem_write_e = 0; pc_src_e = 0;
    stall_e = 0; flush_e = 0; clr_q = 0;
  endtask

  task automatic instr(input logic [3:0] c, input logic [1:0] fw, input logic [4:0] alu,
                       input logic rw, input logic mw, input logic pc);
    valid_e = 1; cond_e = c; flags_write_e = fw; alu_flags_e = alu;
    reg_write_e = rw; mem_write_e = mw; pc_src_e = pc;
    stall_e = 0; flush_e = 0; clr_q = 0;
  endtask

  // Advance one clock; the model commits the same edge from pre-edge inputs.
  task automatic tick();
    logic [4:0] nf;
    logic pass, live, go;
    pass = ref_cond(cond_e, m_flags);
    live = valid_e && !flush_e;
    go   = live && pass;
    nf   = m_flags;
    if (go && flags_write_e[1]) nf[3:2] = alu_flags_e[3:2];
    if (go && flags_write_e[0]) nf[1:0] = alu_flags_e[1:0];
    if (go && flags_write_e != 2'b00 && alu_flags_e[4]) nf[4] = 1'b1;
    else if (clr_q) nf[4] = 1'b0;
    @(posedge clk);
    #1;
    if (!stall_e) begin
      m_flags = nf;
      m_valid = live;
      m_rw    = go && reg_write_e;
      m_mw    = go && mem_write_e;
      m_pc    = go && pc_src_e;
      if (live && !pass && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({flags_q, valid_m, reg_write_m, mem_write_m, pc_src_m, cond_fail_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: got flags=%b vm=%b rw=%b mw=%b pc=%b cnt=%0d required all 0",
               flags_q, valid_m, reg_write_m, mem_write_m, pc_src_m, cond_fail_cnt);
    end
    rst_n = 1;
  endtask

  task automatic test_flags_update();
    instr(4'b1110, 2'b11, 5'b01100, 0, 0, 0);
    #1;
    checks++;
    if (cond_ex_e !== 1'b1) begin
      errors++; $display("FAIL al_pass: got %b required 1", cond_ex_e);
    end
    tick();
    checks++;
    if (flags_q !== 5'b01100) begin
      errors++; $display("FAIL flags_update: got %b required 01100", flags_q);
    end
  endtask

  task automatic test_cond_pass_fail();
    instr(4'b1110, 2'b11, 5'b00100, 0, 0, 0);
    tick();
    instr(4'b0000, 2'b00, 5'b0, 1, 0, 0);
    #1;
    checks++;
    if (cond_ex_e !== 1'b1) begin
      errors++; $display("FAIL eq_pass: got %b required 1", cond_ex_e);
    end
    tick();
    checks++;
    if (reg_write_m !== 1'b1) begin
      errors++; $display("FAIL eq_reg_write_m: got %b required 1", reg_write_m);
    end
    instr(4'b0001, 2'b00, 5'b0, 1, 0, 0);
    #1;
    checks++;
    if (cond_ex_e !== 1'b0) begin
      errors++; $display("FAIL ne_fail: got %b required 0", cond_ex_e);
    end
    tick();
    checks++;
    if ({valid_m, reg_write_m, cond_fail_cnt} !== {1'b1, 1'b0, CW'(1)}) begin
      errors++;
      $display("FAIL ne_outputs: got vm=%b rw=%b cnt=%0d required vm=1 rw=0 cnt=1",
               valid_m, reg_write_m, cond_fail_cnt);
    end
  endtask

  task automatic test_partial_q();
    instr(4'b1110, 2'b11, 5'b01111, 0, 0, 0);
    tick();
    instr(4'b1110, 2'b01, 5'b10000, 0, 0, 0);
    tick();
    checks++;
    if (flags_q !== 5'b11100) begin
      errors++; $display("FAIL partial_write_q_set: got %b required 11100", flags_q);
    end
    instr(4'b1110, 2'b00, 5'b0, 0, 0, 0);
    clr_q = 1;
    tick();
    checks++;
    if (flags_q !== 5'b01100) begin
      errors++; $display("FAIL q_clear: got %b required 01100", flags_q);
    end
    instr(4'b1110, 2'b01, 5'b10011, 0, 0, 0);
    clr_q = 1;
    tick();
    checks++;
    if (flags_q !== 5'b11111) begin
      errors++; $display("FAIL q_set_beats_clear: got %b required 11111", flags_q);
    end
    idle();
    clr_q = 1;
    tick();
    checks++;
    if (flags_q !== 5'b01111) begin
      errors++; $display("FAIL q_clear_no_instr: got %b required 01111", flags_q);
    end
  endtask

  task automatic test_stall_flush();
    logic [4:0] snap_f;
    logic [3:0] snap_m;
    logic [CW-1:0] snap_c;
    instr(4'b1110, 2'b00, 5'b0, 1, 1, 1);
    tick();
    snap_f = flags_q;
    snap_m = {valid_m, reg_write_m, mem_write_m, pc_src_m};
    snap_c = cond_fail_cnt;
    instr(4'b1110, 2'b11, 5'b10101, 0, 0, 0);
    stall_e = 1; flush_e = 1; clr_q = 1;
    tick();
    checks++;
    if ({flags_q, valid_m, reg_write_m, mem_write_m, pc_src_m, cond_fail_cnt}
        !== {snap_f, snap_m, snap_c}) begin
      errors++;
      $display("FAIL stall_hold: got flags=%b m=%b%b%b%b required flags=%b m=%b",
               flags_q, valid_m, reg_write_m, mem_write_m, pc_src_m, snap_f, snap_m);
    end
    instr(4'b1110, 2'b11, 5'b10101, 1, 1, 1);
    flush_e = 1;
    #1;
    checks++;
    if (branch_taken_e !== 1'b0) begin
      errors++; $display("FAIL flush_branch: got %b required 0", branch_taken_e);
    end
    tick();
    checks++;
    if ({valid_m, pc_src_m, flags_q} !== {1'b0, 1'b0, snap_f}) begin
      errors++;
      $display("FAIL flush_squash: got vm=%b pc=%b flags=%b required vm=0 pc=0 flags=%b",
               valid_m, pc_src_m, flags_q, snap_f);
    end
  endtask

  task automatic test_cond_codes();
    logic [3:0] codes [5];
    logic       want  [5];
    codes = '{4'b1111, 4'b1010, 4'b1011, 4'b1100, 4'b1101};
    want  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    instr(4'b1110, 2'b11, 5'b01000, 0, 0, 0);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      cond_e = codes[i];
      #1;
      checks++;
      if (cond_ex_e !== want[i]) begin
        errors++;
        $display("FAIL cond_%b: got %b required %b", codes[i], cond_ex_e, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    instr(4'b1110, 2'b10, 5'b00000, 0, 0, 0);
    tick();
    instr(4'b0001, 2'b10, 5'b00100, 0, 0, 0);
    tick();
    instr(4'b0000, 2'b00, 5'b0, 1, 0, 0);
    #1;
    checks++;
    if (cond_ex_e !== 1'b1) begin
      errors++; $display("FAIL b2b_eq_sees_update: got %b required 1", cond_ex_e);
    end
    tick();
    checks++;
    if (reg_write_m !== 1'b1) begin
      errors++; $display("FAIL b2b_reg_write_m: got %b required 1", reg_write_m);
    end
  endtask

  task automatic test_saturation();
    instr(4'b1110, 2'b11, 5'b11111, 1, 1, 1);
    @(posedge clk);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if ({flags_q, valid_m, reg_write_m, mem_write_m, pc_src_m, cond_fail_cnt} !== '0) begin
      errors++; $display("FAIL async_reset: got flags=%b vm=%b required 0", flags_q, valid_m);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({flags_q, valid_m, reg_write_m, cond_fail_cnt} !== '0) begin
      errors++; $display("FAIL reset_in_flight: got flags=%b vm=%b rw=%b cnt=%0d required 0",
                         flags_q, valid_m, reg_write_m, cond_fail_cnt);
    end
    idle();
    rst_n = 1;
    for (int i = 1; i <= 20; i++) begin
      instr(4'b1111, 2'b00, 5'b0, 1, 0, 0);
      tick();
      checks++;
      if (cond_fail_cnt !== CW'((i < CNT_MAX) ? i : CNT_MAX)) begin
        errors++;
        $display("FAIL cnt_sat_%0d: got %0d required %0d", i, cond_fail_cnt,
                 (i < CNT_MAX) ? i : CNT_MAX);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid_e       = ($urandom_range(0, 3) != 0);
      cond_e        = 4'($urandom);
      flags_write_e = 2'($urandom);
      alu_flags_e   = 5'($urandom);
      reg_write_e   = 1'($urandom);
      mem_write_e   = 1'($urandom);
      pc_src_e      = 1'($urandom);
      stall_e       = ($urandom_range(0, 4) == 0);
      flush_e       = ($urandom_range(0, 5) == 0);
      clr_q         = ($urandom_range(0, 7) == 0);
      #1;
      checks++;
      if ({cond_ex_e, branch_taken_e} !==
          {ref_cond(cond_e, m_flags),
           valid_e && !flush_e && pc_src_e && ref_cond(cond_e, m_flags)}) begin
        errors++;
        $display("FAIL rnd_comb_%0d: got cond=%b br=%b cond_e=%b flags=%b", i,
                 cond_ex_e, branch_taken_e, cond_e, m_flags);
      end
      tick();
      checks++;
      if ({flags_q, valid_m, reg_write_m, mem_write_m, pc_src_m, cond_fail_cnt} !==
          {m_flags, m_valid, m_rw, m_mw, m_pc, CW'(m_cnt)}) begin
        errors++;
        $display("FAIL rnd_regs_%0d: got %b_%b%b%b%b_%0d required %b_%b%b%b%b_%0d", i,
                 flags_q, valid_m, reg_write_m, mem_write_m, pc_src_m, cond_fail_cnt,
                 m_flags, m_valid, m_rw, m_mw, m_pc, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_flags_update();
    test_cond_pass_fail();
    test_partial_q();
    test_stall_flush();
    test_cond_codes();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
